// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - sequencing controller between the CPU and the shift-add multiplier core
//
// Accepts MULT/MULTU requests, hands unsigned magnitudes to the multiplier core,
// waits for the core's ready, applies the sign correction and writes HI/LO.
// Also services MTHI/MTLO and stalls the CPU while a multiply is in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   op_valid, op_signed MULT/MULTU issue request and signedness (1 = MULT)
//   op_a, op_b          rs / rt operands
//   mthi, mtlo, wdata   HI/LO write requests and their data
//   hilo_rd             current instruction is MFHI/MFLO
//   hi, lo              architectural HI/LO registers
//   busy                multiply in flight
//   stall               freeze the CPU this cycle
//   mul_start           core start, one cycle high per multiply
//   mul_a, mul_b        core operands (magnitudes for MULT)
//   mul_product         core product
//   mul_ready           core done

module mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               mthi,
  input  logic               mtlo,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               hilo_rd,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               stall,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Set when exactly one signed operand is negative; the core only sees magnitudes.
  logic neg;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] result;
  logic               accept;
  logic               result_wr;
  logic               idle_wr;

  // Two's-complement negation; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude, so no overflow handling is needed.
  assign abs_a = (op_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
  assign abs_b = (op_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

  // A zero product stays zero after negation, so no negative zero can appear.
  assign result = neg ? (~mul_product + (2*WIDTH)'(1)) : mul_product;

  assign accept    = (state == IDLE) && op_valid;
  assign result_wr = (state == WAIT) && mul_ready;
  // op_valid wins over MTHI/MTLO in the same IDLE cycle.
  assign idle_wr   = (state == IDLE) && !op_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; mul_ready is only looked at in WAIT because the core
  // has no reset and its ready is meaningless until it has been started.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (op_valid) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (mul_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = 1'b0;
    mul_start = 1'b0;
    case (state)
      START: begin
        busy      = 1'b1;
        mul_start = 1'b1;
      end
      WAIT: begin
        busy = 1'b1;
      end
      default: begin
        busy      = 1'b0;
        mul_start = 1'b0;
      end
    endcase
  end

  assign stall = busy && (op_valid || mthi || mtlo || hilo_rd);

  // Operand latch and sign flag; only loaded on an accepted request so that
  // requests arriving while busy leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      neg   <= 1'b0;
    end else if (accept) begin
      mul_a <= abs_a;
      mul_b <= abs_b;
      neg   <= op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end
  end

  // HI/LO change only on a result write, an IDLE MTHI/MTLO, or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (result_wr) begin
      hi <= result[2*WIDTH-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end else if (idle_wr) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb/tb_mult_ctrl.sv - self-checking bench for mult_ctrl with a behavioural multiplier core

module tb_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        hilo_rd = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_product;
  logic        mul_ready;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  // Core model: no reset, ready starts high (stale), loads on start and
  // raises ready core_lat edges later.
  int          core_lat = 256;
  int          core_cnt = 0;
  logic        core_ready = 1'b1;
  logic [63:0] core_prod = '0;

  assign mul_product = core_prod;
  assign mul_ready   = core_ready;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_start === 1'b1) begin
      core_cnt   <= core_lat;
      core_ready <= 1'b0;
      core_prod  <= {32'b0, mul_a} * {32'b0, mul_b};
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_ready <= 1'b1;
    end
  end

  mult_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_signed(op_signed), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hilo_rd(hilo_rd),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_ready(mul_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the architectural product, straight from the operand values.
  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] mag(input bit sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  task automatic run_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit with_mtlo, input string tag);
    int busy_cnt;
    int starts;
    int cyc;
    logic [63:0] p;
    op_valid  = 1'b1;
    op_signed = sgn;
    op_a      = a;
    op_b      = b;
    if (with_mtlo) begin
      mtlo  = 1'b1;
      wdata = 32'h99;
    end
    tick();
    op_valid = 1'b0;
    mtlo     = 1'b0;
    chk({tag, ":hi_hold"}, 64'(hi), 64'(model_hi));
    chk({tag, ":lo_hold"}, 64'(lo), 64'(model_lo));
    chk({tag, ":mul_a"}, 64'(mul_a), 64'(mag(sgn, a)));
    chk({tag, ":mul_b"}, 64'(mul_b), 64'(mag(sgn, b)));
    busy_cnt = 0;
    starts   = 0;
    cyc      = 0;
    while (busy === 1'b1 && cyc < 5000) begin
      busy_cnt++;
      if (mul_start === 1'b1) starts++;
      if (disturb && cyc >= 10 && cyc < 20) begin
        hilo_rd  = 1'b1;
        op_valid = 1'b1;
        op_a     = 32'd2;
        op_b     = 32'd2;
        mtlo     = 1'b1;
        wdata    = 32'h55;
        #1;
        chk({tag, ":stall"}, 64'(stall), 64'd1);
      end else begin
        hilo_rd  = 1'b0;
        op_valid = 1'b0;
        mtlo     = 1'b0;
        if (disturb && cyc == 25) begin
          #1;
          chk({tag, ":no_stall"}, 64'(stall), 64'd0);
          chk({tag, ":hi_mid"}, 64'(hi), 64'(model_hi));
          chk({tag, ":lo_mid"}, 64'(lo), 64'(model_lo));
        end
      end
      tick();
      cyc++;
    end
    hilo_rd  = 1'b0;
    op_valid = 1'b0;
    mtlo     = 1'b0;
    chk({tag, ":latency"}, 64'(busy_cnt), 64'(core_lat + 2));
    chk({tag, ":starts"}, 64'(starts), 64'd1);
    p = ref_mul(sgn, a, b);
    model_hi = p[63:32];
    model_lo = p[31:0];
    chk({tag, ":hi"}, 64'(hi), 64'(model_hi));
    chk({tag, ":lo"}, 64'(lo), 64'(model_lo));
  endtask

  initial begin
    int starts;
    int stall_low;
    int cyc;
    logic [63:0] p;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;

    // Reset state
    repeat (2) tick();
    chk("rst:hi", 64'(hi), 64'd0);
    chk("rst:lo", 64'(lo), 64'd0);
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:stall", 64'(stall), 64'd0);
    chk("rst:mul_start", 64'(mul_start), 64'd0);
    chk("rst:mul_a", 64'(mul_a), 64'd0);
    chk("rst:mul_b", 64'(mul_b), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle:busy", 64'(busy), 64'd0);

    // Full-latency unsigned maximum
    core_lat = 256;
    run_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    chk("multu_max:hi_const", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max:lo_const", 64'(lo), 64'h0000_0001);

    // Signed corner cases
    core_lat = 40;
    run_mult(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult_m3x5");
    chk("mult_m3x5:lo_const", 64'(lo), 64'hFFFF_FFF1);
    run_mult(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "mult_min2");
    chk("mult_min2:hi_const", 64'(hi), 64'h4000_0000);
    run_mult(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, "mult_m7x0");
    chk("mult_m7x0:hi_const", 64'(hi), 64'd0);

    // Requests during busy are stalled and ignored
    core_lat = 256;
    run_mult(1'b1, 32'h0000_1111, 32'hFFFF_2222, 1'b1, 1'b0, "disturb");

    // MTHI / MTLO in IDLE
    mthi = 1'b1; wdata = 32'h1234;
    tick();
    mthi = 1'b0;
    model_hi = 32'h1234;
    chk("mthi:hi", 64'(hi), 64'(model_hi));
    chk("mthi:lo", 64'(lo), 64'(model_lo));
    mtlo = 1'b1; wdata = 32'hABCD;
    tick();
    mtlo = 1'b0;
    model_lo = 32'hABCD;
    chk("mtlo:hi", 64'(hi), 64'h1234);
    chk("mtlo:lo", 64'(lo), 64'hABCD);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    model_hi = 32'h77;
    model_lo = 32'h77;
    chk("mthilo:hi", 64'(hi), 64'(model_hi));
    chk("mthilo:lo", 64'(lo), 64'(model_lo));
    core_lat = 30;
    run_mult(1'b0, 32'd6, 32'd7, 1'b0, 1'b1, "op_plus_mtlo");

    // Back-to-back: second request held from the first accept onward
    core_lat  = 30;
    op_valid  = 1'b1; op_signed = 1'b1; op_a = 32'h1234_5678; op_b = 32'hFEDC_BA98;
    tick();
    op_a = 32'hFFFF_FF9C; op_b = 32'd77;
    starts = 0; stall_low = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 5000) begin
      if (mul_start === 1'b1) starts++;
      if (stall !== 1'b1) stall_low++;
      tick();
      cyc++;
    end
    chk("b2b:stall_held", 64'(stall_low), 64'd0);
    chk("b2b:stall_drop", 64'(stall), 64'd0);
    p = ref_mul(1'b1, 32'h1234_5678, 32'hFEDC_BA98);
    chk("b2b:hi1", 64'(hi), 64'(p[63:32]));
    chk("b2b:lo1", 64'(lo), 64'(p[31:0]));
    tick();
    op_valid = 1'b0;
    chk("b2b:busy2", 64'(busy), 64'd1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 5000) begin
      if (mul_start === 1'b1) starts++;
      tick();
      cyc++;
    end
    chk("b2b:starts", 64'(starts), 64'd2);
    p = ref_mul(1'b1, 32'hFFFF_FF9C, 32'd77);
    model_hi = p[63:32];
    model_lo = p[31:0];
    chk("b2b:hi2", 64'(hi), 64'(model_hi));
    chk("b2b:lo2", 64'(lo), 64'(model_lo));

    // Reset in the middle of a multiply
    core_lat = 256;
    op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd9; op_b = 32'd9;
    tick();
    op_valid = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst:hi", 64'(hi), 64'd0);
    chk("midrst:lo", 64'(lo), 64'd0);
    chk("midrst:busy", 64'(busy), 64'd0);
    chk("midrst:mul_start", 64'(mul_start), 64'd0);
    model_hi = '0;
    model_lo = '0;
    tick();
    rst_n = 1'b1;
    tick();
    run_mult(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, "after_rst");
    chk("after_rst:lo_const", 64'(lo), 64'd12);

    // Randomised operands and core latency
    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom_range(0, 15);
      endcase
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom_range(0, 15);
      endcase
      core_lat = $urandom_range(1, 40);
      run_mult(rs, ra, rb, 1'b0, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Sequencing controller between the multi-cycle CPU control unit and the shift-add 32x32 unsigned multiplier core.
- Accepts MULT/MULTU requests and latches the operands. Converts signed operands to magnitudes, pulses the core's start, waits for its ready, then applies the sign correction.
- Owns the architectural HI/LO registers and services MTHI/MTLO.
- Generates the CPU stall whenever an instruction touches HI/LO while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; product and HI:LO are 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op_valid  input  1  MULT/MULTU issue request
- op_signed  input  1  1 = MULT (signed), 0 = MULTU
- op_a  input  WIDTH  rs operand
- op_b  input  WIDTH  rt operand
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- hilo_rd  input  1  current instruction is MFHI/MFLO
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  multiply in flight
- stall  output  1  freeze the CPU pipeline/FSM this cycle
- mul_start  output  1  core start, level-sampled by the core on clk
- mul_a  output  WIDTH  core multiplicand
- mul_b  output  WIDTH  core multiplier
- mul_product  input  2*WIDTH  core product
- mul_ready  input  1  core done

Behaviour:
Reset (rst_n low, asynchronous):
- State IDLE.
- hi = 0, lo = 0, busy = 0, stall = 0, mul_start = 0, mul_a = 0, mul_b = 0.
- All internal sign flags cleared.

Core interface:
- The core has no reset, so its ready is undefined until its first start.
- The controller samples mul_ready only in state WAIT.

FSM states: IDLE, START, WAIT.
- IDLE: busy = 0.
  - op_valid accepted at the edge. Latch mul_a = |op_a| and mul_b = |op_b| when op_signed; raw values otherwise.
  - Latch neg = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]). Go to START.
  - Magnitude of 0x80000000 is 0x80000000 (unsigned, no overflow).
- START: mul_start = 1 for exactly this one cycle; go to WAIT unconditionally.
- WAIT: mul_start = 0.
  - On mul_ready = 1 at an edge: write {hi,lo} = neg ? (~mul_product + 1) : mul_product. Go to IDLE.
  - Otherwise stay in WAIT.
- busy = 1 in START and WAIT.

Latency:
- Accept edge E0; core loads at E1.
- With the current 256-iteration core, ready is visible after E1+256 and HI/LO are written at E1+257 = E0+258.
- busy falls in the same cycle HI/LO update.
- Correctness depends only on the ready handshake, never on a fixed count.

stall = busy & (op_valid | mthi | mtlo | hilo_rd):
- The CPU holds the instruction until busy drops.
- While busy, op_valid, mthi and mtlo are ignored: no state or register change.

Simultaneous events:
- In IDLE, op_valid has priority over mthi/mtlo; mthi/mtlo in that cycle are dropped.
- mthi and mtlo together in IDLE (no op_valid): both HI and LO are written with wdata.
- MTHI/MTLO in IDLE take effect at the edge; hi/lo update the next cycle.

Reset mid-operation:
- Returns to IDLE immediately and clears HI/LO.
- The next accepted op re-issues start, which reinitialises the core, so a stale mul_ready cannot be consumed.

Other rules:
- hi/lo are registers and change only at: result write, MTHI/MTLO, reset.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high E0..E0+258; mul_start high exactly 1 cycle; hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0. MULT a=-7 b=0 -> hi=0 lo=0 (no negative zero).
- During busy, assert hilo_rd, op_valid(a=2,b=2), mtlo(wdata=0x55) -> stall=1 each cycle; none take effect; final HI/LO equal only the first product.
- IDLE: mthi wdata=0x1234 then mtlo wdata=0xABCD -> hi=0x1234 lo=0xABCD; same cycle op_valid+mtlo -> multiply starts, lo not written by mtlo.
- Drop rst_n at E0+100 of a multiply -> hi=lo=0, busy=0 asynchronously. Then issue MULTU 3x4 -> hi=0 lo=12 after full latency.
- Back-to-back MULT issued the cycle busy falls -> accepted, second result correct, no extra start pulse.
